hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It reads the ID/EX register's load/destination fields, the IF/ID source-register fields, the EX/MEM branch outcome and the data-memory busy flag. From these it drives the write-enable and flush controls for the PC and the IF/ID, ID/EX and EX/MEM registers. A small state machine sequences load-use stalls, memory-wait freezes and branch flushes. Saturating performance counters record stall cycles and flush events.

## Interface
- CNT_W, 32, width of each performance counter
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active high
- id_rs1  input  5  rs1 field of the instruction in IF/ID (inst[19:15])
- id_rs2  input  5  rs2 field of the instruction in IF/ID (inst[24:20])
- id_use_rs1  input  1  instruction in ID reads rs1
- id_use_rs2  input  1  instruction in ID reads rs2
- ex_mem_read  input  1  mem_read output of ID/EX
- ex_rd  input  5  destination-register output of ID/EX
- mem_branch_taken  input  1  EX/MEM branch AND zero: taken branch resolved in MEM
- dmem_busy  input  1  data memory cannot complete this cycle
- pc_write  output  1  PC load enable
- if_id_write  output  1  IF/ID load enable
- id_ex_write  output  1  ID/EX load enable
- ex_mem_write  output  1  EX/MEM load enable
- if_id_flush  output  1  load a NOP into IF/ID
- id_ex_flush  output  1  load a bubble into ID/EX (all control bits 0)
- ex_mem_flush  output  1  load a bubble into EX/MEM
- stall_cnt  output  CNT_W  stall cycles since reset, saturating
- flush_cnt  output  CNT_W  branch flush events since reset, saturating
- state_o  output  2  current state, for debug

## Operation
- States: RUN=0, LU_STALL=1, MEM_WAIT=2. Encoding lives in the shared package.
- load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority within any state: dmem_busy > mem_branch_taken > load_use.
- Defaults are all write enables 1 and all flushes 0.
- dmem_busy, any state:
  - All four write enables are 0 and all flushes are 0.
  - Next state is MEM_WAIT.
  - stall_cnt increments.
- mem_branch_taken with no dmem_busy:
  - if_id_flush, id_ex_flush and ex_mem_flush are 1.
  - Write enables stay 1, so the PC loads the branch target.
  - Next state is RUN. flush_cnt increments.
- load_use in RUN with no higher-priority event:
  - pc_write=0, if_id_write=0, id_ex_flush=1.
  - Next state is LU_STALL. stall_cnt increments.
- LU_STALL: load_use is ignored, which guarantees exactly one bubble per load-use. Next state is RUN unless dmem_busy is set.
- MEM_WAIT: stays while dmem_busy is set. On release, resolve the cycle's events by priority. A branch held frozen in EX/MEM is acted on in that release cycle.
- Counters stop at 2^CNT_W-1 and do not wrap.

## Timing
- Control outputs are combinational from state and inputs: zero-cycle latency, valid within the same cycle.
- The state register and counters update on posedge clk.
- While rst is high:
  - state=RUN, counters=0.
  - All write enables are 0 and all flushes are 0, so the pipeline is frozen.
  - state_o=0.
- The first cycle after rst deasserts follows the normal rules.
- Reset asserted mid-stall or mid-wait returns to RUN immediately with counters cleared.
- A load-use whose ex_rd is x0 never stalls.
- A branch arriving in LU_STALL flushes, overriding the bubble. The next state is RUN.

## Structure
- Shared package hazard_pkg holds:
  - the state encoding constants (ST_RUN, ST_LU_STALL, ST_MEM_WAIT) and the 2-bit state typedef;
  - the NOP instruction constant 32'h00000013 used by the IF/ID flush.
- One sub-module, sat_counter, parameterised by width with an inc input, is instantiated twice.
- Pipeline registers gain a write enable and a flush input driven by this block.

## Test plan
- ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 in RUN -> pc_write=0, if_id_write=0, id_ex_flush=1, state goes to LU_STALL, stall_cnt=1. Next cycle all enables return to 1 and state returns to RUN.
- Same load-use with ex_rd=0 -> no stall; stall_cnt stays 0.
- mem_branch_taken=1 in RUN -> all three flushes 1 for one cycle; flush_cnt=1.
- dmem_busy held 3 cycles together with mem_branch_taken=1 -> all enables 0 for 3 cycles, state_o=2, stall_cnt=3. On release the flushes fire, flush_cnt=1, state returns to RUN.
- load_use then mem_branch_taken=1 in the LU_STALL cycle -> flushes assert, state returns to RUN, and no second bubble is produced.
- Instantiate with CNT_W=4 and apply 20 busy cycles -> stall_cnt holds at 15. Pulse rst mid-wait -> state returns to RUN, counters return to 0, and outputs freeze while rst is high.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and pipeline constants for the hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INST = 32'h00000013;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: event counter that holds at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = (inc && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, memory-wait freeze and branch flush control for the 5-stage pipeline
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch_taken,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_o
);

    state_e state_q, state_d;
    logic   load_use, stall_inc, flush_inc;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

    // The bubble already inserted by LU_STALL resolves the hazard, so load_use is masked there.
    always_comb begin
        state_d      = ST_RUN;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (dmem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            state_d      = ST_MEM_WAIT;
            stall_inc    = 1'b1;
        end else if (mem_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            flush_inc    = 1'b1;
        end else if (load_use && state_q != ST_LU_STALL) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
            state_d      = ST_LU_STALL;
            stall_inc    = 1'b1;
        end
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;

    assign state_o = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

endmodule
